// File: rtl/via_sr_peer.sv
// External serial peer for the 6522 VIA shift register.
// Drives 8 CB1 clocks and either sends a byte on CB2 or samples one from it.
module via_sr_peer #(
    parameter int HPW = 8
) (
    input  logic           clk,
    input  logic           nRESET,
    input  logic           clk_en,
    input  logic           start,
    input  logic           dir,
    input  logic [7:0]     tx_data,
    input  logic [HPW-1:0] half_period,
    output logic           busy,
    output logic           done,
    output logic [7:0]     rx_data,
    output logic           CB1_out,
    output logic           CB1_oe,
    output logic           CB2_out,
    output logic           CB2_oe,
    input  logic           CB2_in
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, TAIL} state_t;

    localparam logic [HPW-1:0] HP_ONE = {{(HPW-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic           dir_q, dir_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [HPW-1:0] hp_q, hp_d;
    logic [HPW-1:0] cnt_q, cnt_d;
    logic [2:0]     bits_q, bits_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           cb1_out_q, cb1_out_d;
    logic           cb1_oe_q, cb1_oe_d;
    logic           cb2_out_q, cb2_out_d;
    logic           cb2_oe_q, cb2_oe_d;
    logic [HPW-1:0] hp_eff;
    logic           last_tick;

    assign hp_eff    = (half_period == '0) ? HP_ONE : half_period;
    assign last_tick = (cnt_q == HP_ONE);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        shreg_d   = shreg_q;
        hp_d      = hp_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        cb1_out_d = cb1_out_q;
        cb1_oe_d  = cb1_oe_q;
        cb2_out_d = cb2_out_q;
        cb2_oe_d  = cb2_oe_q;
        if (clk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = HIGH;
                        dir_d     = dir;
                        shreg_d   = tx_data;
                        hp_d      = hp_eff;
                        cnt_d     = hp_eff;
                        bits_d    = 3'd0;
                        busy_d    = 1'b1;
                        cb1_oe_d  = 1'b1;
                        cb1_out_d = 1'b1;
                        if (!dir) begin
                            cb2_oe_d  = 1'b1;
                            cb2_out_d = tx_data[7];
                        end
                    end
                end
                HIGH: begin
                    if (last_tick) begin
                        // Sample before the falling edge; the VIA moves CB2 on the fall.
                        if (dir_q) shreg_d = {shreg_q[6:0], CB2_in};
                        else       cb2_out_d = shreg_q[7];
                        cb1_out_d = 1'b0;
                        cnt_d     = hp_q;
                        state_d   = LOW;
                    end else begin
                        cnt_d = cnt_q - HP_ONE;
                    end
                end
                LOW: begin
                    if (last_tick) begin
                        cb1_out_d = 1'b1;
                        if (!dir_q) shreg_d = {shreg_q[6:0], 1'b0};
                        bits_d  = bits_q + 3'd1;
                        cnt_d   = hp_q;
                        state_d = (bits_q == 3'd7) ? TAIL : HIGH;
                    end else begin
                        cnt_d = cnt_q - HP_ONE;
                    end
                end
                TAIL: begin
                    if (last_tick) begin
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        cb1_oe_d  = 1'b0;
                        cb2_oe_d  = 1'b0;
                        cb2_out_d = 1'b1;
                        if (dir_q) rx_data_d = shreg_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - HP_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            shreg_q   <= 8'h00;
            hp_q      <= '0;
            cnt_q     <= '0;
            bits_q    <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= 8'h00;
            cb1_out_q <= 1'b1;
            cb1_oe_q  <= 1'b0;
            cb2_out_q <= 1'b1;
            cb2_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            shreg_q   <= shreg_d;
            hp_q      <= hp_d;
            cnt_q     <= cnt_d;
            bits_q    <= bits_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            cb1_out_q <= cb1_out_d;
            cb1_oe_q  <= cb1_oe_d;
            cb2_out_q <= cb2_out_d;
            cb2_oe_q  <= cb2_oe_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign CB1_out = cb1_out_q;
    assign CB1_oe  = cb1_oe_q;
    assign CB2_out = cb2_out_q;
    assign CB2_oe  = cb2_oe_q;

endmodule

// File: tb/tb_via_sr_peer.sv
// Directed bench for via_sr_peer with a small behavioural VIA shift-register
// partner on CB1/CB2.
module tb_via_sr_peer;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic       clk_en = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] half_period = 8'd1;
    logic       CB2_in = 1'b1;
    logic       busy, done, CB1_out, CB1_oe, CB2_out, CB2_oe;
    logic [7:0] rx_data;

    via_sr_peer #(.HPW(8)) dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .start(start),
        .dir(dir), .tx_data(tx_data), .half_period(half_period),
        .busy(busy), .done(done), .rx_data(rx_data),
        .CB1_out(CB1_out), .CB1_oe(CB1_oe),
        .CB2_out(CB2_out), .CB2_oe(CB2_oe), .CB2_in(CB2_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int ticks = 0;
    int div = 0;
    int en_div = 1;
    int falls, rises, done_samples, via_cnt;
    int acc_tick, done_tick;
    logic [7:0] rise_bits, via_sr;
    logic via_in = 1'b0;
    logic via_out = 1'b0;
    logic ifr2, cb1_prev, cb2oe_seen, got_acc, got_done, got_ev;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk: edge, sample #1 later, run the VIA model, set next clk_en.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (clk_en) ticks++;
        if (CB1_out !== cb1_prev) begin
            if (!CB1_out) begin
                falls++;
                if (via_out) via_sr = {via_sr[6:0], via_sr[7]};
            end else begin
                rises++;
                rise_bits = {rise_bits[6:0], CB2_out};
                if (via_in) begin
                    via_sr = {via_sr[6:0], CB2_out};
                    via_cnt++;
                    if (via_cnt == 8) ifr2 = 1'b1;
                end
            end
        end
        cb1_prev = CB1_out;
        if (CB2_oe) cb2oe_seen = 1'b1;
        if (done) done_samples++;
        CB2_in = via_out ? via_sr[7] : 1'b1;
        div = (div + 1) % en_div;
        clk_en = (div == 0);
    endtask

    task automatic clr_mon();
        falls = 0;
        rises = 0;
        done_samples = 0;
        rise_bits = 8'h00;
        cb2oe_seen = 1'b0;
        via_cnt = 0;
        ifr2 = 1'b0;
    endtask

    task automatic begin_xfer(input logic d, input logic [7:0] data,
                              input logic [7:0] hp);
        dir = d;
        tx_data = data;
        half_period = hp;
        clr_mon();
        start = 1'b1;
        got_acc = 1'b0;
        for (int i = 0; i < 20 && !got_acc; i++) begin
            cyc();
            if (busy) got_acc = 1'b1;
        end
        start = 1'b0;
        acc_tick = ticks;
        chk("accept", got_acc, 1);
    endtask

    task automatic wait_done();
        got_done = 1'b0;
        for (int i = 0; i < 2000 && !got_done; i++) begin
            cyc();
            if (done) begin
                got_done = 1'b1;
                done_tick = ticks;
            end
        end
        chk("done_seen", got_done, 1);
        for (int i = 0; i < 4; i++) cyc();
    endtask

    initial begin
        cb1_prev = 1'b1;
        via_sr = 8'h00;
        clr_mon();

        // Reset, with start toggling underneath it
        for (int i = 0; i < 3; i++) begin
            start = i[0];
            cyc();
        end
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_cb1", {CB1_out, CB1_oe}, 2'b10);
        chk("rst_cb2", {CB2_out, CB2_oe}, 2'b10);
        nRESET = 1'b1;
        cyc();
        cb1_prev = CB1_out;

        // Send A5, hp=2, clk_en every 2nd clk
        en_div = 2;
        begin_xfer(1'b0, 8'hA5, 8'd2);
        wait_done();
        chk("send_bits", rise_bits, 8'hA5);
        chk("send_falls", falls, 8);
        chk("send_rises", rises, 8);
        chk("send_lat", done_tick - acc_tick, 34);
        chk("send_donew", done_samples, 1);
        chk("send_oe", {CB1_oe, CB2_oe, CB1_out}, 3'b001);
        chk("send_rxkeep", rx_data, 8'h00);

        // Receive 3C, hp=3, VIA drives bit7 before the first fall
        en_div = 1;
        via_out = 1'b1;
        via_sr = 8'h3C;
        CB2_in = via_sr[7];
        begin_xfer(1'b1, 8'h00, 8'd3);
        wait_done();
        via_out = 1'b0;
        chk("recv_rx", rx_data, 8'h3C);
        chk("recv_oe", cb2oe_seen, 0);
        chk("recv_lat", done_tick - acc_tick, 51);
        chk("recv_falls", falls, 8);

        // hp=0 behaves as hp=1
        begin_xfer(1'b0, 8'h5B, 8'd0);
        wait_done();
        chk("hp0_lat", done_tick - acc_tick, 17);
        chk("hp0_bits", rise_bits, 8'h5B);

        // start / tx_data / half_period / dir changes mid-transfer ignored
        begin_xfer(1'b0, 8'h3C, 8'd2);
        for (int i = 0; i < 10; i++) cyc();
        tx_data = 8'hFF;
        half_period = 8'd5;
        dir = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        start = 1'b0;
        wait_done();
        chk("mid_bits", rise_bits, 8'h3C);
        chk("mid_lat", done_tick - acc_tick, 34);

        // start on the TAIL completion tick is ignored
        begin_xfer(1'b0, 8'h96, 8'd1);
        got_ev = 1'b0;
        for (int i = 0; i < 40 && !got_ev; i++) begin
            if (ticks - acc_tick == 16) got_ev = 1'b1;
            else cyc();
        end
        chk("tail_reach", got_ev, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("tail_done", done, 1);
        chk("tail_busy", busy, 0);
        for (int i = 0; i < 3; i++) cyc();
        chk("tail_ign", busy, 0);
        chk("tail_bits", rise_bits, 8'h96);

        // Reset after the 4th rising edge
        begin_xfer(1'b0, 8'hE7, 8'd2);
        got_ev = 1'b0;
        for (int i = 0; i < 200 && !got_ev; i++) begin
            if (rises == 4) got_ev = 1'b1;
            else cyc();
        end
        chk("rst4_reach", got_ev, 1);
        nRESET = 1'b0;
        cyc();
        nRESET = 1'b1;
        chk("rst4_busy", busy, 0);
        chk("rst4_oe", {CB1_oe, CB2_oe}, 2'b00);
        for (int i = 0; i < 3; i++) cyc();
        chk("rst4_nodone", done_samples, 0);
        begin_xfer(1'b0, 8'h81, 8'd2);
        wait_done();
        chk("rst4_bits", rise_bits, 8'h81);
        chk("rst4_lat", done_tick - acc_tick, 34);

        // Loopback: VIA shifting in under external CB1 (armed by SR read)
        en_div = 3;
        via_in = 1'b1;
        via_sr = 8'h00;
        begin_xfer(1'b0, 8'h5A, 8'd2);
        wait_done();
        via_in = 1'b0;
        chk("lb_via_sr", via_sr, 8'h5A);
        chk("lb_ifr2", ifr2, 1);

        // Loopback: VIA shifting out C3, peer receives
        en_div = 2;
        via_out = 1'b1;
        via_sr = 8'hC3;
        CB2_in = via_sr[7];
        begin_xfer(1'b1, 8'h00, 8'd1);
        wait_done();
        via_out = 1'b0;
        chk("lb_rx", rx_data, 8'hC3);
        chk("lb_oe", cb2oe_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
